pll_rst_seq: RTL and testbench
==============================

Name: pll_rst_seq

Overview:
Reset sequencer that sits directly downstream of the dynamic-phase PLL wrapper and also drives that wrapper's reset input. It holds the PLL in reset for a fixed time, then waits for lock and phase-init done, and then qualifies lock stability. It then releases staged active-low resets to the fabric domains in order. On lock loss, timeout or soft reset, it restarts the whole sequence and counts the restarts.

Parameters:
PLL_RST_CYC, 16, cycles pll_rstn_o is held low in PLL_RST
LOCK_TIMEOUT_CYC, 65536, max cycles in WAIT_LOCK plus WAIT_INIT before forced restart
LOCK_STABLE_CYC, 1024, consecutive synced-lock cycles required in STABLE
STAGE_GAP_CYC, 8, cycles between successive stage reset releases
NUM_STAGES, 4, number of staged reset outputs (1..8)
CNT_W, 17, internal counter width; must hold the largest cycle parameter

Ports:
clk_i  in  1  free-running reference clock (same as PLL clki_i)
rstn_i  in  1  asynchronous active-low reset
pll_lock_i  in  1  PLL lock from wrapper lock_o; asynchronous, synchronized internally
pll_init_done_i  in  1  phase-init done from wrapper done_pll_init_o; asynchronous, synchronized internally
soft_rst_i  in  1  synchronous single-cycle restart request
pll_rstn_o  out  1  active-low reset to the PLL wrapper rstn_i
rst_stage_n_o  out  NUM_STAGES  active-low staged resets; bit 0 is released first
sys_ready_o  out  1  high only in RUN
timeout_o  out  1  sticky; set on a lock/init timeout, cleared only by rstn_i
relock_cnt_o  out  8  saturating count of restarts from any state after PLL_RST
state_o  out  3  current state encoding, for debug

Behaviour:
- Interface: one clock, clk_i. Reset rstn_i is asynchronous and active-low.
- Reset values: state=PLL_RST, counter=0, pll_rstn_o=0, rst_stage_n_o=all 0, sys_ready_o=0, timeout_o=0, relock_cnt_o=0. Synchronizer flops reset to 0.
- Inputs pll_lock_i and pll_init_done_i each pass through a 2-flop synchronizer (2-cycle latency). In the rules below, lock_s and init_s are the synchronized values.
- State encoding: PLL_RST=0, WAIT_LOCK=1, WAIT_INIT=2, STABLE=3, RELEASE=4, RUN=5.
- PLL_RST: pll_rstn_o=0. The counter increments each cycle; at count PLL_RST_CYC-1 the block goes to WAIT_LOCK and the counter clears. pll_rstn_o=1 in every other state.
- WAIT_LOCK: when lock_s=1, go to WAIT_INIT. The timeout counter is not cleared on this transition.
- WAIT_INIT: when init_s=1 and lock_s=1, go to STABLE and clear the counter.
- Timeout: if the combined WAIT_LOCK+WAIT_INIT count reaches LOCK_TIMEOUT_CYC-1 before STABLE, set timeout_o, increment relock_cnt_o and go to PLL_RST.
- STABLE: the counter increments while lock_s=1. At LOCK_STABLE_CYC-1, go to RELEASE and clear the counter.
- RELEASE: the counter increments each cycle. At the end of the cycle with count = STAGE_GAP_CYC*(k+1)-1, rst_stage_n_o[k] goes high and stays high. After the last stage is released, go to RUN on the next edge.
- RUN: sys_ready_o=1. The state holds indefinitely.
- Lock loss: lock_s=0 in WAIT_INIT, STABLE, RELEASE or RUN sends the block to PLL_RST next cycle.
- Restart actions (lock loss, timeout or soft reset): on the same edge, rst_stage_n_o is driven to all 0, sys_ready_o to 0 and pll_rstn_o to 0. The counter clears and relock_cnt_o increments, saturating at 255.
- soft_rst_i: acts as a restart from any state except PLL_RST. In PLL_RST it is ignored and does not increment relock_cnt_o.
- Simultaneous events: soft_rst_i has priority over lock loss, which has priority over timeout and over normal progress. Each of these counts as one increment only.
- Stage ordering: staged outputs only deassert in ascending index order and all reassert together. No glitch is allowed; every output is a direct flop output.
- rstn_i assertion mid-sequence: all outputs return to their reset values immediately (asynchronous).

Decomposition:
- Shared package pll_rst_pkg holds the state enum/localparams (the 3-bit encodings above) and the RELOCK_W=8 constant.
- One natural sub-module: sync_2ff (generic 2-flop synchronizer with async active-low reset), instantiated once per asynchronous input.

Test Plan:
All scenarios use PLL_RST_CYC=4, LOCK_TIMEOUT_CYC=32, LOCK_STABLE_CYC=8, STAGE_GAP_CYC=2, NUM_STAGES=4.
1. Nominal: release rstn_i, raise pll_lock_i at cycle 10 and pll_init_done_i at 15. Required: pll_rstn_o rises after 4 cycles; rst_stage_n_o goes 0001, 0011, 0111, 1111 at 2-cycle spacing; sys_ready_o=1; relock_cnt_o=0.
2. Lock never rises. Required: timeout_o=1 and relock_cnt_o=1 after 32 WAIT cycles; pll_rstn_o low again for 4 cycles; the sequence repeats and relock_cnt_o=2 at the next timeout.
3. Drop pll_lock_i for 1 cycle in RUN. Required: 2 cycles after the drop, rst_stage_n_o=0000, sys_ready_o=0, pll_rstn_o=0, relock_cnt_o=1; full re-sequence on relock.
4. Lock glitch in STABLE at count 5. Required: return to PLL_RST and the stable count restarts at 0; no stage released.
5. soft_rst_i during RELEASE with rst_stage_n_o=0011, with a lock drop in the same cycle. Required: a single increment (relock_cnt_o +1), all stages back to 0; soft_rst_i asserted while in PLL_RST has no effect.
6. Force 300 restarts. Required: relock_cnt_o saturates at 255. Assert rstn_i mid-RELEASE: all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// Shared state encoding and widths for the PLL reset sequencer.
package pll_rst_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned RELOCK_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_WAIT_INIT = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_RUN       = 3'd5
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two back-to-back flops resolve metastability on the asynchronous input.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: PLL reset, lock/init wait, lock qualification and
// staged fabric reset release, restarting on lock loss, timeout or soft reset.
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int unsigned PLL_RST_CYC      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned STAGE_GAP_CYC    = 8,
  parameter int unsigned NUM_STAGES       = 4,
  parameter int unsigned CNT_W            = 17
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  pll_lock_i,
  input  logic                  pll_init_done_i,
  input  logic                  soft_rst_i,
  output logic                  pll_rstn_o,
  output logic [NUM_STAGES-1:0] rst_stage_n_o,
  output logic                  sys_ready_o,
  output logic                  timeout_o,
  output logic [RELOCK_W-1:0]   relock_cnt_o,
  output logic [STATE_W-1:0]    state_o
);

  logic lock_s;
  logic init_s;

  state_e                state_q,    state_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic                  pll_rstn_q, pll_rstn_d;
  logic [NUM_STAGES-1:0] stage_q,    stage_d;
  logic                  ready_q,    ready_d;
  logic                  timeout_q,  timeout_d;
  logic [RELOCK_W-1:0]   relock_q,   relock_d;
  logic                  restart_c;
  logic                  lock_lost_c;

  sync_2ff #(.W(1)) u_sync_lock (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (pll_lock_i),
    .q_o    (lock_s)
  );

  sync_2ff #(.W(1)) u_sync_init (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (pll_init_done_i),
    .q_o    (init_s)
  );

  // State, counter and all outputs are flops so every reset output is glitch-free.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_PLL_RST;
      cnt_q      <= '0;
      pll_rstn_q <= 1'b0;
      stage_q    <= '0;
      ready_q    <= 1'b0;
      timeout_q  <= 1'b0;
      relock_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pll_rstn_q <= pll_rstn_d;
      stage_q    <= stage_d;
      ready_q    <= ready_d;
      timeout_q  <= timeout_d;
      relock_q   <= relock_d;
    end
  end

  // Next-state logic; soft reset beats lock loss, which beats timeout and progress.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    stage_d     = stage_q;
    timeout_d   = timeout_q;
    relock_d    = relock_q;
    restart_c   = 1'b0;
    lock_lost_c = !lock_s && (state_q inside {ST_WAIT_INIT, ST_STABLE, ST_RELEASE, ST_RUN});

    if (soft_rst_i && (state_q != ST_PLL_RST)) begin
      restart_c = 1'b1;
    end else if (lock_lost_c) begin
      restart_c = 1'b1;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == CNT_W'(PLL_RST_CYC - 1)) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
            restart_c = 1'b1;
            timeout_d = 1'b1;
          end else if (lock_s) begin
            state_d = ST_WAIT_INIT;
          end
        end
        ST_WAIT_INIT: begin
          if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
            restart_c = 1'b1;
            timeout_d = 1'b1;
          end else if (init_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end
        end
        ST_STABLE: begin
          if (cnt_q == CNT_W'(LOCK_STABLE_CYC - 1)) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end
        end
        ST_RELEASE: begin
          for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (cnt_q == CNT_W'(STAGE_GAP_CYC * (k + 1) - 1)) stage_d[k] = 1'b1;
          end
          if (&stage_q) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end

    if (restart_c) begin
      state_d = ST_PLL_RST;
      cnt_d   = '0;
      stage_d = '0;
      if (relock_q != '1) relock_d = relock_q + RELOCK_W'(1);
    end

    pll_rstn_d = (state_d != ST_PLL_RST);
    ready_d    = (state_d == ST_RUN);
  end

  assign pll_rstn_o    = pll_rstn_q;
  assign rst_stage_n_o = stage_q;
  assign sys_ready_o   = ready_q;
  assign timeout_o     = timeout_q;
  assign relock_cnt_o  = relock_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq against a phase/elapsed-time reference model.
module tb_pll_rst_seq;

  localparam int unsigned P_RST = 4;
  localparam int unsigned P_TO  = 32;
  localparam int unsigned P_STB = 8;
  localparam int unsigned P_GAP = 2;
  localparam int unsigned P_NS  = 4;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            pll_lock_i;
  logic            pll_init_done_i;
  logic            soft_rst_i;
  logic            pll_rstn_o;
  logic [P_NS-1:0] rst_stage_n_o;
  logic            sys_ready_o;
  logic            timeout_o;
  logic [7:0]      relock_cnt_o;
  logic [2:0]      state_o;

  always #5 clk_i = ~clk_i;

  pll_rst_seq #(
    .PLL_RST_CYC      (P_RST),
    .LOCK_TIMEOUT_CYC (P_TO),
    .LOCK_STABLE_CYC  (P_STB),
    .STAGE_GAP_CYC    (P_GAP),
    .NUM_STAGES       (P_NS),
    .CNT_W            (17)
  ) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .pll_lock_i      (pll_lock_i),
    .pll_init_done_i (pll_init_done_i),
    .soft_rst_i      (soft_rst_i),
    .pll_rstn_o      (pll_rstn_o),
    .rst_stage_n_o   (rst_stage_n_o),
    .sys_ready_o     (sys_ready_o),
    .timeout_o       (timeout_o),
    .relock_cnt_o    (relock_cnt_o),
    .state_o         (state_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase label plus elapsed cycles in that phase.
  int m_phase, m_t, m_wt, m_st, m_rt, m_relock;
  bit m_timeout;
  bit lk_p1, lk_p2, in_p1, in_p2;

  function automatic void model_reset();
    m_phase = 0; m_t = 0; m_wt = 0; m_st = 0; m_rt = 0; m_relock = 0;
    m_timeout = 0; lk_p1 = 0; lk_p2 = 0; in_p1 = 0; in_p2 = 0;
  endfunction

  function automatic void model_edge(input bit lk_in, input bit in_in, input bit sr);
    bit lk  = lk_p2;
    bit ini = in_p2;
    bit rs  = 0;
    bit to  = 0;
    if (m_phase != 0 && sr) rs = 1;
    else if (m_phase >= 2 && !lk) rs = 1;
    else begin
      case (m_phase)
        0: begin
          m_t++;
          if (m_t == P_RST) begin m_phase = 1; m_wt = 0; end
        end
        1, 2: begin
          m_wt++;
          if (m_wt == P_TO) begin rs = 1; to = 1; end
          else if (m_phase == 1) begin if (lk) m_phase = 2; end
          else if (ini) begin m_phase = 3; m_st = 0; end
        end
        3: begin
          m_st++;
          if (m_st == P_STB) begin m_phase = 4; m_rt = 0; end
        end
        4: begin
          if (m_rt >= P_GAP * P_NS) m_phase = 5;
          else m_rt++;
        end
        default: ;
      endcase
    end
    if (rs) begin
      m_phase = 0; m_t = 0;
      if (m_relock < 255) m_relock++;
      if (to) m_timeout = 1;
    end
    lk_p2 = lk_p1; lk_p1 = lk_in;
    in_p2 = in_p1; in_p1 = in_in;
  endfunction

  function automatic logic [P_NS-1:0] exp_stage();
    logic [P_NS-1:0] s = '0;
    if (m_phase == 5) s = '1;
    else if (m_phase == 4)
      for (int k = 0; k < P_NS; k++) if (m_rt >= P_GAP * (k + 1)) s[k] = 1'b1;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_edge(pll_lock_i, pll_init_done_i, soft_rst_i);
    #1;
    check_eq("state",    32'(state_o),       32'(m_phase));
    check_eq("pll_rstn", 32'(pll_rstn_o),    32'(m_phase != 0));
    check_eq("stage",    32'(rst_stage_n_o), 32'(exp_stage()));
    check_eq("ready",    32'(sys_ready_o),   32'(m_phase == 5));
    check_eq("timeout",  32'(timeout_o),     32'(m_timeout));
    check_eq("relock",   32'(relock_cnt_o),  32'(m_relock));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_state"},  32'(state_o),       32'd0);
    check_eq({tag, "_rstn"},   32'(pll_rstn_o),    32'd0);
    check_eq({tag, "_stage"},  32'(rst_stage_n_o), 32'd0);
    check_eq({tag, "_ready"},  32'(sys_ready_o),   32'd0);
    check_eq({tag, "_tmo"},    32'(timeout_o),     32'd0);
    check_eq({tag, "_relock"}, 32'(relock_cnt_o),  32'd0);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0; pll_lock_i = 1'b0; pll_init_done_i = 1'b0; soft_rst_i = 1'b0;
    #1;
    check_reset_vals("rst");
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    rstn_i = 1'b1;
  endtask

  task automatic wait_phase(input int target, input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc && m_phase != target; i++) tick();
    check_eq(tag, 32'(state_o), 32'(target));
  endtask

  logic [P_NS-1:0] seen[$];
  logic [P_NS-1:0] stage_exp_tab [4];
  int              stb_cnt;

  initial begin
    stage_exp_tab[0] = 4'b0001; stage_exp_tab[1] = 4'b0011;
    stage_exp_tab[2] = 4'b0111; stage_exp_tab[3] = 4'b1111;

    // Nominal bring-up with lock at cycle 10 and init done at cycle 15.
    do_reset();
    for (int c = 1; c <= 45; c++) begin
      if (c == 10) pll_lock_i = 1'b1;
      if (c == 15) pll_init_done_i = 1'b1;
      tick();
      if (c == 3) check_eq("nom_rstn_low",  32'(pll_rstn_o), 32'd0);
      if (c == 4) check_eq("nom_rstn_high", 32'(pll_rstn_o), 32'd1);
      if (rst_stage_n_o != 0 && (seen.size() == 0 || seen[$] != rst_stage_n_o))
        seen.push_back(rst_stage_n_o);
    end
    check_eq("nom_seq_len", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      check_eq("nom_seq", 32'(seen[i]), 32'(stage_exp_tab[i]));
    check_eq("nom_ready",  32'(sys_ready_o),  32'd1);
    check_eq("nom_relock", 32'(relock_cnt_o), 32'd0);

    // Lock never rises: repeated timeouts.
    do_reset();
    for (int c = 1; c <= 72; c++) begin
      tick();
      if (c == 35) check_eq("to_before", 32'(timeout_o), 32'd0);
      if (c == 36) begin
        check_eq("to_set",      32'(timeout_o),    32'd1);
        check_eq("to_relock1",  32'(relock_cnt_o), 32'd1);
        check_eq("to_rstn_low", 32'(pll_rstn_o),   32'd0);
      end
      if (c == 40) check_eq("to_rstn_high", 32'(pll_rstn_o), 32'd1);
    end
    check_eq("to_relock2", 32'(relock_cnt_o), 32'd2);

    // One-cycle lock drop in RUN.
    do_reset();
    pll_lock_i = 1'b1; pll_init_done_i = 1'b1;
    wait_phase(5, 80, "drop_reach_run");
    pll_lock_i = 1'b0;
    tick();
    pll_lock_i = 1'b1;
    tick();
    check_eq("drop_still_run", 32'(sys_ready_o), 32'd1);
    tick();
    check_eq("drop_stage",  32'(rst_stage_n_o), 32'd0);
    check_eq("drop_ready",  32'(sys_ready_o),   32'd0);
    check_eq("drop_rstn",   32'(pll_rstn_o),    32'd0);
    check_eq("drop_relock", 32'(relock_cnt_o),  32'd1);
    wait_phase(5, 80, "drop_rerun");

    // Lock glitch in STABLE at count 5; stable count restarts.
    do_reset();
    pll_lock_i = 1'b1; pll_init_done_i = 1'b1;
    for (int i = 0; i < 80 && !(m_phase == 3 && m_st == 3); i++) tick();
    check_eq("glitch_in_stable", 32'(state_o), 32'd3);
    pll_lock_i = 1'b0;
    tick();
    pll_lock_i = 1'b1;
    tick();
    tick();
    check_eq("glitch_state",  32'(state_o),       32'd0);
    check_eq("glitch_stage",  32'(rst_stage_n_o), 32'd0);
    check_eq("glitch_relock", 32'(relock_cnt_o),  32'd1);
    stb_cnt = 0;
    for (int i = 0; i < 80 && m_phase != 4; i++) begin
      tick();
      if (state_o == 3'd3) stb_cnt++;
    end
    check_eq("glitch_stable_len", 32'(stb_cnt), 32'(P_STB));

    // Soft reset coinciding with lock loss during RELEASE.
    do_reset();
    pll_lock_i = 1'b1; pll_init_done_i = 1'b1;
    for (int i = 0; i < 80 && !(m_phase == 4 && m_rt == 2); i++) tick();
    pll_lock_i = 1'b0;
    tick();
    pll_lock_i = 1'b1;
    tick();
    check_eq("soft_pre_stage", 32'(rst_stage_n_o), 32'b0011);
    soft_rst_i = 1'b1;
    tick();
    soft_rst_i = 1'b0;
    check_eq("soft_relock", 32'(relock_cnt_o),  32'd1);
    check_eq("soft_stage",  32'(rst_stage_n_o), 32'd0);
    soft_rst_i = 1'b1;
    tick();
    soft_rst_i = 1'b0;
    check_eq("soft_in_rst", 32'(relock_cnt_o), 32'd1);
    repeat (10) tick();

    // Randomized lock/init/soft activity against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (pll_lock_i) begin if ($urandom_range(0, 99) < 2) pll_lock_i = 1'b0; end
      else if ($urandom_range(0, 99) < 25) pll_lock_i = 1'b1;
      if (pll_init_done_i) begin if ($urandom_range(0, 99) < 3) pll_init_done_i = 1'b0; end
      else if ($urandom_range(0, 99) < 20) pll_init_done_i = 1'b1;
      soft_rst_i = ($urandom_range(0, 99) < 1);
      tick();
    end
    soft_rst_i = 1'b0;

    // Saturation of the restart counter.
    do_reset();
    pll_lock_i = 1'b1; pll_init_done_i = 1'b1;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 20 && m_phase == 0; i++) tick();
      soft_rst_i = 1'b1;
      tick();
      soft_rst_i = 1'b0;
    end
    check_eq("sat_relock", 32'(relock_cnt_o), 32'd255);

    // Asynchronous reset mid-RELEASE.
    for (int i = 0; i < 80 && !(m_phase == 4 && m_rt == 3); i++) tick();
    check_eq("async_in_release", 32'(state_o), 32'd4);
    #2;
    rstn_i = 1'b0;
    #1;
    check_reset_vals("async");
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    rstn_i = 1'b1;
    wait_phase(5, 80, "async_rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
